// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, signed/unsigned,
// flush (annul) and divide-by-zero support, result held until start_i drops.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dsr;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] result_q;

    logic               accept;
    logic               stepping;
    logic               finishing;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_nxt;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    assign accept    = (state == S_IDLE) && start_i && !annul_i;
    assign stepping  = (state == S_ON) && !annul_i && (cnt != CNT_LAST);
    assign finishing = (state == S_ON) && !annul_i && (cnt == CNT_LAST);

    // A shifted partial remainder with its top bit set already exceeds any
    // WIDTH-bit divisor; otherwise the borrow of the WIDTH+1 bit subtract decides.
    assign shifted = {rem, dvd[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr};
    assign q_bit   = shifted[WIDTH] | ~diff[WIDTH];
    assign rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                cnt <= '0;
            end else if (stepping) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: state_nxt = S_END;
            S_ON: begin
                if (annul_i) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_END;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers carry no reset; outputs are gated by state instead.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem   <= '0;
            dvd   <= magnitude(opdata1_i, signed_div_i);
            dsr   <= magnitude(opdata2_i, signed_div_i);
            neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r <= signed_div_i && opdata1_i[WIDTH-1];
        end else if (stepping) begin
            rem <= rem_nxt;
            dvd <= {dvd[WIDTH-2:0], q_bit};
        end

        if (finishing) begin
            result_q <= {sign_fix(rem, neg_r), sign_fix(dvd, neg_q)};
        end else if (state == S_BYZERO) begin
            result_q <= '0;
        end
    end

    assign ready_o  = (state == S_END);
    assign busy_o   = (state == S_ON) || (state == S_BYZERO);
    assign result_o = ready_o ? result_q : '0;

endmodule
